viterbi_decoder: RTL and testbench

//  Hard-decision Viterbi decoder for the rate-1/2 convolutional code produced by conv_encoder.

---
 rtl/viterbi_pkg.sv | 15 +
 rtl/viterbi_acs.sv | 14 +
 rtl/viterbi_decoder.sv | 116 +++++++++++
 tb/tb_viterbi_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared defaults, FSM state codes and the trellis branch-symbol helper
package viterbi_pkg;
  localparam int K_DEF = 3;
  localparam logic [7:0] G0_DEF = 8'o07;
  localparam logic [7:0] G1_DEF = 8'o05;
  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  function automatic logic [1:0] branch_sym(input logic [7:0] s, input logic b, input logic [7:0] g0,
                                            input logic [7:0] g1);
    logic [7:0] r;
    r = {s[6:0], b};
    return {^(r & g0), ^(r & g1)};
  endfunction
endpackage

// File: rtl/viterbi_acs.sv
// viterbi_acs: compare-select of two candidate path metrics
//  i_c0/i_c1 candidate metrics via predecessor x=0/x=1
//  o_metric  surviving metric; o_dec = 1 when x=1 wins (ties keep x=0)
module viterbi_acs #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_c0,
  input  logic [W-1:0] i_c1,
  output logic [W-1:0] o_metric,
  output logic         o_dec
);
  assign o_dec = i_c1 < i_c0;
  assign o_metric = o_dec ? i_c1 : i_c0;
endmodule

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision register-exchange Viterbi decoder for rate-1/2 conv code
//  clk, rst          clock, synchronous active-high reset
//  sym_in/sym_valid  received {y0,y1} symbol; accepted when sym_ready
//  flush             pulse to drain the remaining bits; busy while draining
//  bit_out/bit_valid decoded bit stream, oldest first
//  best_metric       minimum path metric, present only with VITERBI_METRIC_OUT_EN defined
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int         K        = K_DEF,
  parameter logic [7:0] G0_OCT   = G0_DEF,
  parameter logic [7:0] G1_OCT   = G1_DEF,
  parameter int         TB_DEPTH = 15,
  parameter int         METRIC_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  input  logic       flush,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       busy
`ifdef VITERBI_METRIC_OUT_EN
  ,
  output logic [METRIC_W-1:0] best_metric
`endif
);
  localparam int M = K - 1;
  localparam int NS = 1 << M;
  localparam int D = TB_DEPTH;
  localparam int CW = $clog2(D + 1);
  localparam logic [METRIC_W-1:0] M_INIT = METRIC_W'(1) << (METRIC_W - 2);
  logic [METRIC_W-1:0] r_metric [NS];
  logic [D-1:0] r_path [NS];
  logic [CW-1:0] r_cnt, r_rem;
  logic [1:0] r_state;
  logic r_bit_out, r_bit_valid;
  logic [METRIC_W-1:0] w_acs [NS];
  logic [METRIC_W-1:0] w_new [NS];
  logic [D-1:0] w_path [NS];
  logic [M-1:0] w_best;
  logic [CW-1:0] w_cnt_nx;
  logic w_norm, w_acc, w_to_run, w_emit_run, w_emit_fl, w_start, w_init;
  for (genvar n = 0; n < NS; n++) begin : g_acs
    localparam int P0 = n >> 1;
    localparam int P1 = P0 + (1 << (M - 1));
    localparam logic B = (n % 2) == 1;
    logic [1:0] w_e0, w_e1;
    logic w_dec;
    assign w_e0 = branch_sym(8'(P0), B, G0_OCT, G1_OCT) ^ sym_in;
    assign w_e1 = branch_sym(8'(P1), B, G0_OCT, G1_OCT) ^ sym_in;
    viterbi_acs #(.W(METRIC_W)) u_acs (
      .i_c0    (r_metric[P0] + METRIC_W'(w_e0[1]) + METRIC_W'(w_e0[0])),
      .i_c1    (r_metric[P1] + METRIC_W'(w_e1[1]) + METRIC_W'(w_e1[0])),
      .o_metric(w_acs[n]),
      .o_dec   (w_dec)
    );
    assign w_path[n] = {w_dec ? r_path[P1][D-2:0] : r_path[P0][D-2:0], B};
  end
  // clearing the MSB only when all metrics have it set keeps their ordering intact
  always_comb begin
    w_norm = 1'b1;
    for (int s = 0; s < NS; s++) w_norm = w_norm & w_acs[s][METRIC_W-1];
    for (int s = 0; s < NS; s++) w_new[s] = w_norm ? {1'b0, w_acs[s][METRIC_W-2:0]} : w_acs[s];
    w_best = '0;
    for (int s = 1; s < NS; s++) w_best = w_new[s] < w_new[w_best] ? M'(s) : w_best;
  end
  assign w_acc = sym_valid && r_state != ST_FLUSH;
  assign w_cnt_nx = r_cnt + CW'(w_acc && r_state == ST_FILL);
  // the D-th symbol both fills the survivors and yields the first bit
  assign w_to_run = r_state == ST_RUN || w_cnt_nx == CW'(D);
  assign w_emit_run = w_acc && w_to_run;
  assign w_start = flush && r_state != ST_FLUSH;
  assign w_emit_fl = r_state == ST_FLUSH && r_rem != '0;
  // reinit on the edge that drains the last bit, or at once when nothing is left
  assign w_init = r_state == ST_FLUSH && r_rem <= CW'(1);
  always_ff @(posedge clk) begin
    if (rst || w_init) begin
      for (int s = 0; s < NS; s++) begin
        r_metric[s] <= s == 0 ? '0 : M_INIT;
        r_path[s] <= '0;
      end
      r_cnt <= '0;
      r_state <= ST_FILL;
    end else begin
      if (w_acc) begin
        r_metric <= w_new;
        r_path <= w_path;
        r_cnt <= w_cnt_nx;
      end
      r_state <= w_start ? ST_FLUSH : w_emit_run ? ST_RUN : r_state;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_out <= 1'b0;
      r_bit_valid <= 1'b0;
      r_rem <= '0;
    end else begin
      r_bit_valid <= w_emit_run || w_emit_fl;
      r_bit_out <= w_emit_run ? w_path[w_best][D-1] : w_emit_fl ? r_path[0][r_rem - CW'(1)] : r_bit_out;
      r_rem <= w_start ? (w_to_run ? CW'(D - 1) : w_cnt_nx) : w_emit_fl ? r_rem - CW'(1) : r_rem;
    end
  end
`ifdef VITERBI_METRIC_OUT_EN
  logic [METRIC_W-1:0] r_best_metric;
  always_ff @(posedge clk) r_best_metric <= rst ? '0 : w_acc ? w_new[w_best] : r_best_metric;
  assign best_metric = r_best_metric;
`endif
  assign sym_ready = r_state != ST_FLUSH;
  assign busy = r_state == ST_FLUSH;
  assign bit_out = r_bit_out;
  assign bit_valid = r_bit_valid;
endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: scoreboard bench for viterbi_decoder against a reference encoder and decoder model
module tb_viterbi_decoder;
  localparam int D = 15;
  localparam int MW = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] sym_in = '0;
  logic sym_valid = 1'b0;
  logic flush = 1'b0;
  logic sym_ready, bit_out, bit_valid, busy;
`ifdef VITERBI_METRIC_OUT_EN
  logic [MW-1:0] best_metric;
`endif
  int n_chk = 0;
  int n_err = 0;
  int n_pulse = 0;
  logic exp_q[$];
  bit use_model = 1'b0;
  int m_met[4];
  logic [63:0] m_hist[4];
  int m_t;
  logic [1:0] enc_s;
  logic [1:0] fr[7] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
  logic fr_bits[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  viterbi_decoder #(.TB_DEPTH(D), .METRIC_W(MW)) u_dut (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .flush(flush), .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy)
`ifdef VITERBI_METRIC_OUT_EN
    , .best_metric(best_metric)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // reference code (7,5): y0 = b^s0^s1, y1 = b^s1, s0 newest
  function automatic logic [1:0] enc(input logic [1:0] s, input logic b);
    return {b ^ s[0] ^ s[1], b ^ s[1]};
  endfunction

  function automatic int ham(input logic [1:0] a, input logic [1:0] b);
    return int'(a[1] ^ b[1]) + int'(a[0] ^ b[0]);
  endfunction

  task automatic m_reset();
    for (int n = 0; n < 4; n++) begin
      m_met[n] = n == 0 ? 0 : 1 << (MW - 2);
      m_hist[n] = '0;
    end
    m_t = 0;
  endtask

  // unbounded integer metrics: any wrap or bad normalization in the DUT shows up as divergence
  task automatic m_step(input logic [1:0] sy);
    int nm[4];
    logic [63:0] nh[4];
    int p, c0, c1, best;
    logic b;
    for (int n = 0; n < 4; n++) begin
      b = (n % 2) == 1;
      p = n / 2;
      c0 = m_met[p] + ham(enc(2'(p), b), sy);
      c1 = m_met[p + 2] + ham(enc(2'(p + 2), b), sy);
      nm[n] = c1 < c0 ? c1 : c0;
      if (c1 < c0) p = p + 2;
      nh[n] = {m_hist[p][62:0], b};
    end
    m_met = nm;
    m_hist = nh;
    m_t++;
    best = 0;
    for (int n = 1; n < 4; n++) if (m_met[n] < m_met[best]) best = n;
    if (m_t >= D) exp_q.push_back(m_hist[best][D-1]);
  endtask

  task automatic m_flush();
    if (m_t >= D) for (int i = D - 2; i >= 0; i--) exp_q.push_back(m_hist[0][i]);
    else for (int i = m_t - 1; i >= 0; i--) exp_q.push_back(m_hist[0][i]);
    m_reset();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [1:0] s, input logic fl);
    sym_in = s;
    sym_valid = 1'b1;
    flush = fl;
    tick();
    sym_valid = 1'b0;
    flush = 1'b0;
    if (use_model) begin
      m_step(s);
      if (fl) m_flush();
    end
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 60) begin
      tick();
      i++;
    end
    chk("flush_end", busy, 0);
    repeat (2) tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if (use_model) m_flush();
    wait_idle();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bit_valid) begin
        n_pulse++;
        if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
        else chk("bit", bit_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [1:0] sy;
    logic b;
    repeat (3) tick();
    chk("rst_valid", bit_valid, 0);
    chk("rst_ready", sym_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    n_pulse = 0;
    for (int i = 0; i < 7; i++) exp_q.push_back(fr_bits[i]);
    for (int i = 0; i < 7; i++) send_sym(fr[i], 1'b0);
    chk("fill_quiet", n_pulse, 0);
    do_flush();
    chk("clean_cnt", n_pulse, 7);
    n_pulse = 0;
    for (int i = 0; i < 7; i++) exp_q.push_back(fr_bits[i]);
    for (int i = 0; i < 7; i++) send_sym(i == 1 ? 2'b11 : fr[i], 1'b0);
    do_flush();
    chk("err1_cnt", n_pulse, 7);
    n_pulse = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("zero_busy_hi", busy, 1);
    tick();
    chk("zero_busy_lo", busy, 0);
    repeat (2) tick();
    chk("zero_cnt", n_pulse, 0);
    n_pulse = 0;
    for (int i = 0; i < 7; i++) exp_q.push_back(fr_bits[i]);
    for (int i = 0; i < 6; i++) send_sym(fr[i], 1'b0);
    send_sym(fr[6], 1'b1);
    chk("coinc_busy", busy, 1);
    wait_idle();
    chk("coinc_cnt", n_pulse, 7);
    n_pulse = 0;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 7; i++) send_sym(fr[i], 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_fl_busy", busy, 0);
    chk("rst_fl_ready", sym_ready, 1);
    repeat (4) tick();
    chk("rst_fl_cnt", n_pulse, 2);
    n_pulse = 0;
    enc_s = '0;
    for (int i = 0; i < 1002; i++) begin
      b = i < 1000 ? 1'($urandom_range(0, 1)) : 1'b0;
      sy = enc(enc_s, b);
      enc_s = {enc_s[0], b};
      exp_q.push_back(b);
      send_sym(sy, 1'b0);
      if (i == 13) chk("lat_pre_cnt", n_pulse, 0);
      if (i == 13) chk("lat_pre", bit_valid, 0);
      if (i == 14) chk("lat_first", bit_valid, 1);
      repeat ($urandom_range(0, 2)) tick();
    end
    do_flush();
    chk("stream_cnt", n_pulse, 1002);
    n_pulse = 0;
    use_model = 1'b1;
    m_reset();
    for (int i = 0; i < 400; i++) begin
      send_sym(2'($urandom_range(0, 3)), 1'b0);
      repeat ($urandom_range(0, 1)) tick();
    end
    do_flush();
    use_model = 1'b0;
    chk("model_cnt", n_pulse, 400);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
